sum_fifo: RTL and testbench
===========================

SUM_FIFO -- requirements
Module: sum_fifo

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of result entries; SHALL be a power of two, 2..16.
REQ-002 Parameter W, default 4, meaning width of the sum and index fields.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 reset_L  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  sum30_dd/idx_dd hold a valid adder-pipeline result this cycle.
REQ-006 sum30_dd  input  W  sum from the pipelined adder output stage.
REQ-007 idx_dd  input  W  index from the pipelined adder output stage.
REQ-008 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-009 out_valid  output  1  head entry is present.
REQ-010 out_sum / out_idx  output  W each  head entry fields; 0 when empty.
REQ-011 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-012 full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 overflow  output  1  sticky flag: a valid result was dropped.
REQ-014 acc  output  2W  running sum of popped results (only with SUM_FIFO_ACC_EN).

Function
REQ-015 Push SHALL occur when in_valid and (not full, or pop in the same cycle); the entry {idx_dd, sum30_dd} is written at the write pointer.
REQ-016 Pop SHALL occur when out_valid and out_ready; the read pointer advances.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged, including when full and when count==1.
REQ-018 No bypass: a value pushed into an empty FIFO at edge N SHALL appear on out_* with out_valid=1 after edge N (1-cycle latency), never combinationally in the same cycle.
REQ-019 out_sum/out_idx SHALL be driven from the head entry with no added register stage; they SHALL be 0 when empty.
REQ-020 in_valid while full with no pop SHALL drop the input, leave storage/pointers unchanged, and set overflow=1 at that edge.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 out_ready while empty SHALL have no effect.
REQ-023 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH or underflow.
REQ-024 Ordering SHALL be strictly first-in first-out.

Reset
REQ-025 On reset_L=0, asynchronously: pointers=0, count=0, out_valid=0, out_sum=0, out_idx=0, full=0, empty=1, overflow=0, acc=0.
REQ-026 Storage contents need not be cleared; reset mid-operation discards all entries.
REQ-027 The first push SHALL be accepted on the first rising edge with reset_L=1.

Configuration
REQ-028 Macro SUM_FIFO_ACC_EN defined: acc port exists; on each pop acc <= acc + zero-extended out_sum, wrapping modulo 2^(2W).
REQ-029 SUM_FIFO_ACC_EN undefined: acc port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package sum_pkg SHALL hold DEPTH/W defaults and the entry struct type {idx, sum}.
REQ-031 Storage SHALL be a sub-module sum_fifo_mem (DEPTH x 2W, one write port, one asynchronous read port); control stays in sum_fifo.

Verification
REQ-032 Reset, then in_valid=1 for 3 cycles with (idx,sum)=(0,F),(1,0),(2,1), out_ready=0 -> count=3, out_idx=0, out_sum=F, empty=0.
REQ-033 Fill 4 entries, then in_valid=1 with idx=4, out_ready=0 -> full=1, overflow=1, entry dropped; drain yields idx 0,1,2,3 only.
REQ-034 Full, in_valid=1 and out_ready=1 in the same cycle -> count stays 4, head advances to idx 1, overflow stays 0.
REQ-035 Push 6 entries and pop continuously with out_ready=1 -> pointers wrap, outputs idx 0..5 in order, each one cycle after its push.
REQ-036 With SUM_FIFO_ACC_EN, pop sums F,0,1,2 -> acc=0x12; assert reset_L=0 mid-stream -> acc=0, count=0, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared definitions for the sum_fifo block.
// Holds the default geometry, the entry layout {idx, sum} and a pointer-width helper.
package sum_pkg;

   localparam int SUM_DEPTH_DEF = 4;
   localparam int SUM_W_DEF     = 4;

   // One stored adder result; idx occupies the upper half of the packed word.
   typedef struct packed {
      logic [SUM_W_DEF-1:0] idx;
      logic [SUM_W_DEF-1:0] sum;
   } sum_entry_t;

   // Pointer width for a given depth (at least one bit).
   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sum_fifo_mem.sv
// Storage array for sum_fifo: DEPTH words of EW bits.
// One synchronous write port and one asynchronous read port, so the FIFO head
// reaches the outputs without an extra register stage. Contents are not reset.
module sum_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int EW    = 8,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [EW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [EW-1:0] rd_data
);

   logic [EW-1:0] mem [DEPTH];

   // Write the incoming entry at the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sum_fifo.sv
// sum_fifo: result FIFO behind a pipelined adder.
// Stores {idx, sum} pairs, presents the head entry directly from storage, and
// flags (stickily) any result dropped while full. Defining SUM_FIFO_ACC_EN adds
// the acc port: a wrapping running sum of every popped out_sum.
module sum_fifo
   import sum_pkg::*;
#(
   parameter int DEPTH = SUM_DEPTH_DEF,
   parameter int W     = SUM_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset_L,
   input  logic                   in_valid,
   input  logic [W-1:0]           sum30_dd,
   input  logic [W-1:0]           idx_dd,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [W-1:0]           out_sum,
   output logic [W-1:0]           out_idx,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow
`ifdef SUM_FIFO_ACC_EN
   ,
   output logic [2*W-1:0]         acc
`endif
);

   localparam int AW = ptr_bits(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = 2 * W;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          overflow_reg;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // Head is valid whenever anything is stored; no bypass from the input.
   assign out_valid = (count_reg != '0);
   assign empty     = ~out_valid;
   assign full      = (count_reg == CW'(DEPTH));
   assign count     = count_reg;
   assign overflow  = overflow_reg;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign pop  = out_valid & out_ready;
   assign push = in_valid & (~full | pop);

   // Head fields come straight from storage and read as zero when empty.
   assign out_idx = out_valid ? head[EW-1:W] : '0;
   assign out_sum = out_valid ? head[W-1:0]  : '0;

   sum_fifo_mem #(
      .DEPTH (DEPTH),
      .EW    (EW),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_reg),
      .wr_data ({idx_dd, sum30_dd}),
      .rd_addr (rd_ptr_reg),
      .rd_data (head)
   );

   // Occupancy update: simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_next = count_reg;
      unique case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointers, count and the sticky overflow flag.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_next;
         // A valid input that could not be pushed was dropped.
         if (in_valid && !push) begin
            overflow_reg <= 1'b1;
         end
      end
   end

`ifdef SUM_FIFO_ACC_EN
   logic [EW-1:0] acc_reg;

   assign acc = acc_reg;

   // Accumulate each popped sum, wrapping at the accumulator width.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         acc_reg <= '0;
      end else if (pop) begin
         acc_reg <= acc_reg + {{W{1'b0}}, out_sum};
      end
   end
`endif

endmodule

// File: tb/tb_sum_fifo.sv
// Directed, table-driven bench for sum_fifo (DEPTH=4, W=4).
// Builds with or without SUM_FIFO_ACC_EN; accumulator checks only in the former.
module tb_sum_fifo;
   import sum_pkg::*;

   localparam int DEPTH = 4;
   localparam int W     = 4;

   logic                   clk = 1'b0;
   logic                   reset_L;
   logic                   in_valid;
   logic [W-1:0]           sum30_dd;
   logic [W-1:0]           idx_dd;
   logic                   out_ready;
   logic                   out_valid;
   logic [W-1:0]           out_sum;
   logic [W-1:0]           out_idx;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   overflow;
`ifdef SUM_FIFO_ACC_EN
   logic [2*W-1:0]         acc;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       v;
      sum_entry_t in;
      logic       rdy;
      int         cnt;
      sum_entry_t head;
      logic       fl;
      logic       of;
   } vec_t;

   vec_t vecs[$];

   sum_fifo #(.DEPTH(DEPTH), .W(W)) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .in_valid  (in_valid),
      .sum30_dd  (sum30_dd),
      .idx_dd    (idx_dd),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_idx   (out_idx),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
`ifdef SUM_FIFO_ACC_EN
      ,
      .acc       (acc)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] i, input logic [3:0] s,
                               input logic rdy, input int cnt, input logic [3:0] hi,
                               input logic [3:0] hs, input logic fl, input logic of);
      vec_t r;
      r.v = v; r.in.idx = i; r.in.sum = s; r.rdy = rdy; r.cnt = cnt;
      r.head.idx = hi; r.head.sum = hs; r.fl = fl; r.of = of;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [3:0] i, input logic [3:0] s, input logic rdy);
      in_valid  = v;
      idx_dd    = i;
      sum30_dd  = s;
      out_ready = rdy;
   endtask

   // One clock edge, then settle away from the edge before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int cnt, input logic [3:0] hi,
                              input logic [3:0] hs, input logic fl, input logic of);
      check({tag, " count"},     32'(count),     32'(cnt));
      check({tag, " out_valid"}, 32'(out_valid), 32'(cnt != 0));
      check({tag, " empty"},     32'(empty),     32'(cnt == 0));
      check({tag, " out_idx"},   32'(out_idx),   32'(hi));
      check({tag, " out_sum"},   32'(out_sum),   32'(hs));
      check({tag, " full"},      32'(full),      32'(fl));
      check({tag, " overflow"},  32'(overflow),  32'(of));
   endtask

   initial begin
      // v idx sum rdy | cnt hidx hsum full ovf
      vecs.push_back(mk(1, 4'h0, 4'hF, 0, 1, 4'h0, 4'hF, 0, 0)); // first push after reset
      vecs.push_back(mk(1, 4'h1, 4'h0, 0, 2, 4'h0, 4'hF, 0, 0));
      vecs.push_back(mk(1, 4'h2, 4'h1, 0, 3, 4'h0, 4'hF, 0, 0)); // count 3, head (0,F)
      vecs.push_back(mk(1, 4'h3, 4'h2, 0, 4, 4'h0, 4'hF, 1, 0)); // full
      vecs.push_back(mk(1, 4'h4, 4'h3, 1, 4, 4'h1, 4'h0, 1, 0)); // push+pop while full
      vecs.push_back(mk(1, 4'h5, 4'h4, 0, 4, 4'h1, 4'h0, 1, 1)); // dropped, overflow
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 4, 4'h1, 4'h0, 1, 1)); // idle hold
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 3, 4'h2, 4'h1, 0, 1)); // drain
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 2, 4'h3, 4'h2, 0, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 1, 4'h4, 4'h3, 0, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 1)); // empty, outputs zero
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 1)); // pop while empty ignored
      vecs.push_back(mk(1, 4'h0, 4'h5, 1, 1, 4'h0, 4'h5, 0, 1)); // streaming, pointers wrap
      vecs.push_back(mk(1, 4'h1, 4'h6, 1, 1, 4'h1, 4'h6, 0, 1));
      vecs.push_back(mk(1, 4'h2, 4'h7, 1, 1, 4'h2, 4'h7, 0, 1));
      vecs.push_back(mk(1, 4'h3, 4'h8, 1, 1, 4'h3, 4'h8, 0, 1));
      vecs.push_back(mk(1, 4'h4, 4'h9, 1, 1, 4'h4, 4'h9, 0, 1));
      vecs.push_back(mk(1, 4'h5, 4'hA, 1, 1, 4'h5, 4'hA, 0, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 1));

      reset_L = 1'b0;
      drive(0, 4'h0, 4'h0, 0);
      #12;
      check_state("reset", 0, 4'h0, 4'h0, 0, 0);
`ifdef SUM_FIFO_ACC_EN
      check("reset acc", 32'(acc), 32'h0);
`endif
      reset_L = 1'b1;

      // No bypass: a push request must not show up before the edge.
      drive(1, 4'h0, 4'hF, 0);
      #1;
      check("nobypass out_valid", 32'(out_valid), 32'h0);
      check("nobypass out_sum",   32'(out_sum),   32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].in.idx, vecs[i].in.sum, vecs[i].rdy);
         step();
         check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].head.idx,
                     vecs[i].head.sum, vecs[i].fl, vecs[i].of);
      end

      // Asynchronous reset clears the sticky overflow without a clock edge.
      reset_L = 1'b0;
      #1;
      check("async ovf clear", 32'(overflow), 32'h0);
      check("async count",     32'(count),    32'h0);
      #1;
      reset_L = 1'b1;

      // Accumulator sequence: push F,0,1,2 then pop all four.
      drive(1, 4'h0, 4'hF, 0); step();
      drive(1, 4'h1, 4'h0, 0); step();
      drive(1, 4'h2, 4'h1, 0); step();
      drive(1, 4'h3, 4'h2, 0); step();
      check_state("acc fill", 4, 4'h0, 4'hF, 1, 0);
      drive(0, 4'h0, 4'h0, 1); step();
      check("acc pop1 idx", 32'(out_idx), 32'h1);
      step();
      check("acc pop2 idx", 32'(out_idx), 32'h2);
      step();
      check("acc pop3 idx", 32'(out_idx), 32'h3);
      step();
      check_state("acc drained", 0, 4'h0, 4'h0, 0, 0);
`ifdef SUM_FIFO_ACC_EN
      check("acc total", 32'(acc), 32'h12);
`endif

      // Reset mid-stream discards stored entries immediately.
      drive(1, 4'h7, 4'h9, 0); step();
      drive(1, 4'h8, 4'h3, 0); step();
      check("pre-reset count", 32'(count), 32'h2);
      drive(0, 4'h0, 4'h0, 0);
      reset_L = 1'b0;
      #1;
      check_state("midreset", 0, 4'h0, 4'h0, 0, 0);
`ifdef SUM_FIFO_ACC_EN
      check("midreset acc", 32'(acc), 32'h0);
`endif
      #1;
      reset_L = 1'b1;
      drive(1, 4'h6, 4'hC, 0); step();
      check_state("post-reset push", 1, 4'h6, 4'hC, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
